// File: rtl/frame_capture_pkg.sv
// Shared types and default geometry for the frame capture controller.
// Holds the FSM state enum, the RGB888 pixel struct and the grayscale helper
// used when FRAME_CAPTURE_GRAY_EN is defined.
package frame_capture_pkg;

    localparam int PIX_W = 24;

    // Default camera and window geometry (640x480 source, 128x128 capture).
    localparam int DEF_SRC_W = 640;
    localparam int DEF_SRC_H = 480;
    localparam int DEF_DST_W = 128;
    localparam int DEF_DST_H = 128;
    localparam int DEF_STEP  = 3;
    localparam int DEF_X0    = 128;
    localparam int DEF_Y0    = 48;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        PAD,
        DONE
    } cap_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Y = (R + 2G + B) >> 2; a 10-bit sum cannot overflow (max 1020).
    function automatic rgb888_t rgb_to_gray(input rgb888_t p);
        logic [9:0] sum;
        sum = {2'b00, p.r} + {1'b0, p.g, 1'b0} + {2'b00, p.b};
        return '{r: sum[9:2], g: sum[9:2], b: sum[9:2]};
    endfunction

endpackage

// File: rtl/pix_pos_tracker.sv
// Source pixel position tracker.
// Follows the (x, y) position of every valid pixel and keeps modulo-STEP phase
// counters relative to the window origin, so the decimation grid is found
// without dividers. o_qualify marks the pixel currently on the bus.
module pix_pos_tracker
    import frame_capture_pkg::*;
#(
    parameter int SRC_W = DEF_SRC_W,
    parameter int SRC_H = DEF_SRC_H,
    parameter int DST_W = DEF_DST_W,
    parameter int DST_H = DEF_DST_H,
    parameter int STEP  = DEF_STEP,
    parameter int X0    = DEF_X0,
    parameter int Y0    = DEF_Y0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_sof,
    output logic o_qualify
);

    localparam int XW = $clog2(SRC_W + 1);
    localparam int YW = $clog2(SRC_H + 1);
    localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(SRC_H - 1);
    localparam logic [XW-1:0] X_LO    = XW'(X0);
    localparam logic [XW-1:0] X_HI    = XW'(X0 + STEP * DST_W);
    localparam logic [YW-1:0] Y_LO    = YW'(Y0);
    localparam logic [YW-1:0] Y_HI    = YW'(Y0 + STEP * DST_H);
    localparam logic [PW-1:0] PH_LAST = PW'(STEP - 1);

    // *_q hold the position and phase of the next pixel to arrive.
    logic [XW-1:0] x_q, x_d, cur_x;
    logic [YW-1:0] y_q, y_d, cur_y;
    logic [PW-1:0] xph_q, xph_d, cur_xph;
    logic [PW-1:0] yph_q, yph_d, cur_yph;
    logic          wrap;

    // Resolve the current pixel's position and derive the next one.
    always_comb begin
        // A sof pixel is (0,0) regardless of what the counters expected.
        cur_x   = i_sof ? '0 : x_q;
        cur_y   = i_sof ? '0 : y_q;
        cur_xph = i_sof ? '0 : xph_q;
        cur_yph = i_sof ? '0 : yph_q;
        wrap    = (cur_x == X_LAST);

        x_d   = wrap ? '0 : cur_x + XW'(1);
        // Phase restarts exactly at the window edge; outside it is don't-care.
        xph_d = (x_d == X_LO || cur_xph == PH_LAST) ? '0 : cur_xph + PW'(1);

        y_d   = cur_y;
        yph_d = cur_yph;
        // y saturates on the last line so an over-long frame never aliases.
        if (wrap && cur_y != Y_LAST) begin
            y_d   = cur_y + YW'(1);
            yph_d = (y_d == Y_LO || cur_yph == PH_LAST) ? '0 : cur_yph + PW'(1);
        end

        o_qualify = i_valid
                 && cur_x >= X_LO && cur_x < X_HI
                 && cur_y >= Y_LO && cur_y < Y_HI
                 && cur_xph == '0 && cur_yph == '0;
    end

    // Advance the position counters on every valid pixel.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (i_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            xph_q <= '0;
            yph_q <= '0;
        end else if (i_valid) begin
            x_q   <= x_d;
            y_q   <= y_d;
            xph_q <= xph_d;
            yph_q <= yph_d;
        end
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller feeding the 128x128 image RAM controller.
// On i_start it arms, waits for the next start of frame, and writes exactly
// DST_W*DST_H decimated pixels; a truncated frame is padded with zeros so the
// downstream address counter stays frame-aligned.
// Optional: define FRAME_CAPTURE_GRAY_EN to write {Y,Y,Y} grayscale pixels.
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int SRC_W = DEF_SRC_W,
    parameter int SRC_H = DEF_SRC_H,
    parameter int DST_W = DEF_DST_W,
    parameter int DST_H = DEF_DST_H,
    parameter int STEP  = DEF_STEP,
    parameter int X0    = DEF_X0,
    parameter int Y0    = DEF_Y0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [PIX_W-1:0] i_data,
    output logic             o_wen,
    output logic [PIX_W-1:0] o_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int N_PIX = DST_W * DST_H;
    localparam int WC_W  = $clog2(N_PIX) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(N_PIX - 1);

    if (X0 + STEP * DST_W > SRC_W || Y0 + STEP * DST_H > SRC_H) begin : g_geom_err
        $error("frame_capture_ctrl: capture window exceeds the source frame");
    end

    cap_state_e       state_q;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             wen_q, busy_q, done_q, err_q;
    logic [PIX_W-1:0] data_q;
    rgb888_t          wr_pix_d;
    logic             qualify, take_px, px_last;

    pix_pos_tracker #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
        .STEP(STEP), .X0(X0), .Y0(Y0)
    ) u_pos (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .o_qualify(qualify)
    );

`ifdef FRAME_CAPTURE_GRAY_EN
    assign wr_pix_d = rgb_to_gray(rgb888_t'(i_data));
`else
    assign wr_pix_d = rgb888_t'(i_data);
`endif

    assign wcnt_d = wcnt_q + WC_W'(1);

    // Decide whether the pixel on the bus is written and whether it is the last.
    always_comb begin
        take_px = 1'b0;
        // The sof pixel that leaves ARM is judged by the capture rules too.
        if (qualify) begin
            take_px = (state_q == CAPTURE) || (state_q == ARM && i_sof);
        end
        px_last = take_px && (wcnt_q == WC_LAST);
    end

    // Capture FSM with registered write strobe, data and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            wen_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;

            if (take_px) begin
                wen_q  <= 1'b1;
                data_q <= wr_pix_d;
                wcnt_q <= wcnt_d;
            end

            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        err_q   <= 1'b0;
                        wcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (i_valid && i_sof) begin
                        if (px_last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // Completion wins over a coincident sof.
                    if (px_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (i_valid && i_sof) begin
                        state_q <= PAD;
                        err_q   <= 1'b1;
                    end
                end
                PAD: begin
                    wen_q  <= 1'b1;
                    data_q <= '0;
                    wcnt_q <= wcnt_d;
                    if (wcnt_q == WC_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_wen  = wen_q;
    assign o_data = data_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule
